user_bram_responder: RTL and testbench
======================================

Name: user_bram_responder

Overview:
- Memory-side responder for the user-project BRAM interface driven by the FIR DMA engine: A0/Di0/WE0 in, Do0 out.
- Holds a word-addressed memory array that the DMA reads from and writes to.
- Models the fixed 10-cycle read latency the DMA is built around.
- Also serves a Wishbone slave port for firmware, so firmware can load input samples and read results. The DMA port has priority.

Parameters:
- pADDR_WIDTH, 12, memory word-address width; depth = 2**pADDR_WIDTH words.
- pDATA_WIDTH, 32, data width.
- pDELAY, 10, read latency in clock cycles on both ports; legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- dma_sel  input  1  DMA owns the port this cycle.
- A0  input  pDATA_WIDTH  DMA word address; low pADDR_WIDTH bits are used.
- Di0  input  pDATA_WIDTH  DMA write data.
- WE0  input  4  DMA byte write enables.
- Do0  output  pDATA_WIDTH  DMA read data, pDELAY cycles after the address.
- Do0_valid  output  1  Do0 carries a returned read.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_we_i  input  1  Wishbone write.
- wbs_sel_i  input  4  Wishbone byte selects.
- wbs_adr_i  input  32  Wishbone byte address; word index = adr[pADDR_WIDTH+1:2].
- wbs_dat_i  input  pDATA_WIDTH  Wishbone write data.
- wbs_dat_o  output  pDATA_WIDTH  Wishbone read data, valid when ack is high.
- wbs_ack_o  output  1  single-cycle acknowledge.

Behaviour:
- Reset (async, active-high):
  - Do0=0, Do0_valid=0, wbs_ack_o=0, wbs_dat_o=0.
  - DMA read pipeline and Wishbone FSM cleared.
  - Memory contents are not reset.
- DMA read:
  - Every cycle with dma_sel=1 and WE0==0 issues a read of mem[A0].
  - The read is fully pipelined: one issue per cycle.
  - Data returns on Do0 exactly pDELAY cycles later, with Do0_valid=1 for that cycle.
  - Cycles without an issue shift a bubble through the pipeline: Do0_valid=0, Do0 holds its last value.
- DMA write:
  - dma_sel=1 with any WE0 bit set writes Di0 into mem[A0] at that clock edge, per byte lane.
  - No response is returned.
- Read-during-write, same address, same edge: the read returns the old data.
- Wishbone FSM, states IDLE, WAIT, ACK:
  - IDLE: on wbs_cyc_i & wbs_stb_i, capture adr, we, sel and dat, load the delay counter with pDELAY-1, go to WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 0, go to ACK.
  - A read samples mem[word index] in the cycle the counter reaches 0, into wbs_dat_o.
  - A write commits in the cycle the counter reaches 0.
  - If dma_sel=1 with WE0!=0 in that cycle, the Wishbone commit stalls: stay in WAIT with the counter at 0 and retry the next cycle.
  - ACK: wbs_ack_o=1 for exactly one cycle, then return to IDLE. The FSM does not re-accept in the ACK cycle.
  - Net latency for an unstalled access: accept at cycle t, ack at cycle t+pDELAY.
- Port priority:
  - The DMA port always wins the memory write port.
  - Wishbone reads never stall; the memory has two read ports.
- Wishbone strobe dropped mid-transaction: the captured transaction still completes and acks. The master must ignore it.
- Address wrap: the upper address bits are ignored, so addresses alias modulo the depth.
- Byte lanes: lane k covers bits [8k+7:8k] on both ports.
- Reset asserted mid-operation: in-flight DMA reads and a pending Wishbone access are discarded, with no ack. Writes already committed are kept.

Test Plan:
- Wishbone write 0xDEADBEEF to byte address 0x10, then read 0x10 -> ack 10 cycles after each accept; read data 0xDEADBEEF.
- DMA burst: dma_sel=1, A0=0..7 on consecutive cycles with memory preloaded to mem[i]=i*3 -> Do0=0,3,...,21 with Do0_valid high on 8 consecutive cycles, starting 10 cycles after the first address.
- Collision: Wishbone write to word 5 reaches its commit cycle while the DMA writes word 9 -> ack delayed by one cycle (at t+11); mem[9]=DMA data, mem[5]=Wishbone data.
- Byte enables: mem[2]=0x11223344, DMA write 0xAABBCCDD with WE0=4'b0101 -> readback 0x11BB33DD.
- Read-during-write: A0=3 with a write of 0x55 while mem[3]=0x77, with a read issued on the same edge -> the read returns 0x77 and a subsequent read returns 0x55.
- Reset mid-burst: assert rst 4 cycles into an 8-read DMA burst and a pending Wishbone read -> Do0_valid stays 0 and no ack appears; memory contents are unchanged.

Source files
------------

// File: rtl/user_bram_responder.sv
// user_bram_responder
//   Memory-side responder for the FIR DMA BRAM port plus a Wishbone slave
//   port for firmware. Both ports share one word-addressed array.
//
//   clk, rst        : clock, asynchronous active-high reset
//   dma_sel         : DMA owns the port this cycle
//   A0/Di0/WE0      : DMA word address, write data, byte write enables
//   Do0/Do0_valid   : DMA read data, returned pDELAY cycles after issue
//   wbs_*           : Wishbone slave (byte address, single-cycle ack,
//                     ack pDELAY cycles after accept unless a write stalls)
//
//   DMA writes always win the write port; a Wishbone write that reaches its
//   commit cycle while the DMA is writing retries on the next cycle. Reads
//   never conflict (two read ports). Memory contents survive reset.
module user_bram_responder #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pDELAY      = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dma_sel,
  input  logic [pDATA_WIDTH-1:0] A0,
  input  logic [pDATA_WIDTH-1:0] Di0,
  input  logic [3:0]             WE0,
  output logic [pDATA_WIDTH-1:0] Do0,
  output logic                   Do0_valid,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [pDATA_WIDTH-1:0] wbs_dat_i,
  output logic [pDATA_WIDTH-1:0] wbs_dat_o,
  output logic                   wbs_ack_o
);
  localparam int DEPTH = 1 << pADDR_WIDTH;
  localparam int NB    = 4;

  typedef enum logic [1:0] {WB_IDLE, WB_WAIT, WB_ACK} wb_state_t;

  typedef struct packed {
    logic                   we;
    logic [3:0]             sel;
    logic [pADDR_WIDTH-1:0] idx;
    logic [pDATA_WIDTH-1:0] dat;
  } wb_req_t;

  logic [pDATA_WIDTH-1:0] mem [DEPTH];

  // upper address bits alias; byte-offset bits of the WB address are ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{A0[pDATA_WIDTH-1:pADDR_WIDTH],
                              wbs_adr_i[31:pADDR_WIDTH+2], wbs_adr_i[1:0]};

  logic [pADDR_WIDTH-1:0] dma_idx;
  logic                   dma_rd, dma_wr;
  assign dma_idx = A0[pADDR_WIDTH-1:0];
  assign dma_rd  = dma_sel && (WE0 == 4'b0000);
  assign dma_wr  = dma_sel && (WE0 != 4'b0000);

  // ---------------- Wishbone request tracking ----------------
  wb_state_t state;
  logic [3:0] cnt;
  wb_req_t    req_q, req_in, req_cur;
  logic       wb_accept, wb_due, wb_stall, wb_wr, wb_rd;

  always_comb begin
    req_in     = '0;
    req_in.we  = wbs_we_i;
    req_in.sel = wbs_sel_i;
    req_in.idx = wbs_adr_i[pADDR_WIDTH+1:2];
    req_in.dat = wbs_dat_i;
  end

  assign wb_accept = (state == WB_IDLE) && wbs_cyc_i && wbs_stb_i;
  // with a 1-cycle latency the commit happens on the accept edge itself
  assign req_cur   = (state == WB_IDLE) ? req_in : req_q;
  // cnt==1 is the edge where the count reaches 0; cnt==0 only after a stall
  assign wb_due    = (wb_accept && (pDELAY == 1)) ||
                     ((state == WB_WAIT) && (cnt <= 4'd1));
  assign wb_stall  = wb_due && req_cur.we && dma_wr;
  assign wb_wr     = wb_due && req_cur.we && !dma_wr && !rst;
  assign wb_rd     = wb_due && !req_cur.we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WB_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      if (wb_rd) wbs_dat_o <= mem[req_cur.idx];
      case (state)
        WB_IDLE: begin
          if (wb_accept) begin
            req_q <= req_in;
            cnt   <= 4'(pDELAY - 1);
            if (wb_due && !wb_stall) begin
              state     <= WB_ACK;
              wbs_ack_o <= 1'b1;
            end else begin
              state <= WB_WAIT;
            end
          end
        end
        WB_WAIT: begin
          if (wb_due) begin
            if (wb_stall) begin
              cnt <= '0;
            end else begin
              state     <= WB_ACK;
              wbs_ack_o <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WB_ACK: begin
          wbs_ack_o <= 1'b0;
          state     <= WB_IDLE;
        end
        default: begin
          wbs_ack_o <= 1'b0;
          state     <= WB_IDLE;
        end
      endcase
    end
  end

  // ---------------- memory write port (not reset) ----------------
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (dma_wr && WE0[k])
        mem[dma_idx][8*k +: 8] <= Di0[8*k +: 8];
      else if (wb_wr && req_cur.sel[k])
        mem[req_cur.idx][8*k +: 8] <= req_cur.dat[8*k +: 8];
    end
  end

  // ---------------- DMA read pipeline ----------------
  // Stage data only advances behind a valid bit, so the last stage (Do0)
  // holds the most recent returned word through bubbles.
  logic [pDELAY-1:0]                  vld_pipe;
  logic [pDELAY-1:0][pDATA_WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= dma_rd;
      if (dma_rd) dat_pipe[0] <= mem[dma_idx];
      for (int i = 1; i < pDELAY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign Do0       = dat_pipe[pDELAY-1];
  assign Do0_valid = vld_pipe[pDELAY-1];
endmodule

// File: tb/tb_user_bram_responder.sv
module tb_user_bram_responder;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int D  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          dma_sel;
  logic [DW-1:0] A0, Di0, Do0;
  logic [3:0]    WE0;
  logic          Do0_valid;
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ack_o;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_adr_i;
  logic [DW-1:0] wbs_dat_i, wbs_dat_o;

  user_bram_responder #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pDELAY(D)) dut (
    .clk(clk), .rst(rst), .dma_sel(dma_sel), .A0(A0), .Di0(Di0), .WE0(WE0),
    .Do0(Do0), .Do0_valid(Do0_valid),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [31:0] d;
    bit          chk_d;
  } exp_t;

  exp_t        dq[$];
  exp_t        wq[$];
  logic [31:0] mdl [0:4095];
  int          n_chk = 0;
  int          n_pass = 0;
  int          seen_v = 0;
  int          seen_a = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (be[k]) m[8*k +: 8] = 8'hFF;
    return (old & ~m) | (nw & m);
  endfunction

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (Do0_valid) begin
        seen_v++;
        if (dq.size() == 0) check("dma_unexpected_valid", 1, 0);
        else begin
          e = dq.pop_front();
          check("dma_cycle", cyc, e.t);
          check("dma_data", Do0, e.d);
        end
      end
      if (wbs_ack_o) begin
        seen_a++;
        if (wq.size() == 0) check("wb_unexpected_ack", 1, 0);
        else begin
          e = wq.pop_front();
          check("wb_ack_cycle", cyc, e.t);
          if (e.chk_d) check("wb_rdata", wbs_dat_o, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    dma_sel = 0; A0 = '0; Di0 = '0; WE0 = '0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = '0;
    wbs_adr_i = '0; wbs_dat_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic dma_read(input logic [31:0] a);
    exp_t e;
    tick();
    dma_sel = 1; A0 = a; WE0 = 4'b0000;
    e.t = cyc + D; e.d = mdl[a[AW-1:0]]; e.chk_d = 1;
    dq.push_back(e);
  endtask

  task automatic dma_read_lit(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    tick();
    dma_sel = 1; A0 = a; WE0 = 4'b0000;
    e.t = cyc + D; e.d = d; e.chk_d = 1;
    dq.push_back(e);
  endtask

  task automatic dma_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    tick();
    dma_sel = 1; A0 = a; Di0 = d; WE0 = be;
    mdl[a[AW-1:0]] = merge(mdl[a[AW-1:0]], d, be);
  endtask

  task automatic wb_pins(input bit we, input logic [31:0] adr, input logic [31:0] d,
                         input logic [3:0] sel);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = adr;
    wbs_dat_i = d; wbs_sel_i = sel;
  endtask

  // one-cycle strobe; extra = stall cycles the stimulus arranges
  task automatic wb_issue(input bit we, input logic [31:0] adr, input logic [31:0] d,
                          input logic [3:0] sel, input int extra);
    exp_t        e;
    logic [11:0] idx;
    tick();
    wb_pins(we, adr, d, sel);
    idx = adr[AW+1:2];
    e.t = cyc + D + extra;
    if (we) begin
      mdl[idx] = merge(mdl[idx], d, sel);
      e.d = '0; e.chk_d = 0;
    end else begin
      e.d = mdl[idx]; e.chk_d = 1;
    end
    wq.push_back(e);
  endtask

  task automatic wb_wait();
    int k;
    k = 0;
    while (!wbs_ack_o && k < 40) begin
      tick();
      k++;
    end
    if (k >= 40) check("wb_ack_timeout", 0, 1);
  endtask

  initial begin
    logic [11:0] idx;
    logic [31:0] a;
    int          r;

    rst = 1;
    tick();
    idle(2);
    check("rst_Do0", Do0, 0);
    check("rst_Do0_valid", Do0_valid, 0);
    check("rst_ack", wbs_ack_o, 0);
    check("rst_dat_o", wbs_dat_o, 0);
    rst = 0;
    idle(2);

    // Wishbone write then read back
    wb_issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    wb_wait();
    wb_issue(0, 32'h10, '0, 4'hF, 0);
    wb_wait();

    // DMA burst mem[i] = i*3
    for (int i = 0; i < 8; i++) dma_write(i, i * 3, 4'hF);
    for (int i = 0; i < 8; i++) dma_read_lit(i, i * 3);
    idle(D + 2);

    // Wishbone write stalled by a DMA write on its commit cycle
    wb_issue(1, 32'h5 << 2, 32'hCAFE0005, 4'hF, 1);
    idle(D - 2);
    dma_write(9, 32'h0BAD0009, 4'hF);
    wb_wait();
    dma_read_lit(9, 32'h0BAD0009);
    dma_read_lit(5, 32'hCAFE0005);
    idle(D + 2);

    // byte enables
    dma_write(2, 32'h11223344, 4'hF);
    dma_write(2, 32'hAABBCCDD, 4'b0101);
    dma_read_lit(2, 32'h11BB33DD);
    idle(D + 2);

    // read-during-write: WB read of word 3 samples on the DMA write edge
    dma_write(3, 32'h77, 4'hF);
    wb_issue(0, 32'h3 << 2, '0, 4'hF, 0);
    idle(D - 2);
    dma_write(3, 32'h55, 4'hF);
    wb_wait();
    wb_issue(0, 32'h3 << 2, '0, 4'hF, 0);
    wb_wait();
    dma_read_lit(3, 32'h55);
    idle(D + 2);

    // randomized DMA traffic with aliased upper address bits
    for (int i = 0; i < 64; i++) dma_write(i, $urandom, 4'hF);
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 9);
      idx = 12'($urandom_range(0, 63));
      a   = ($urandom & 32'hFFFF_F000) | 32'(idx);
      if (r < 5) dma_read(a);
      else if (r < 8) dma_write(a, $urandom, 4'($urandom_range(1, 15)));
      else idle(1);
    end
    idle(D + 2);

    // randomized Wishbone traffic
    for (int i = 0; i < 30; i++) begin
      idx = 12'($urandom_range(0, 63));
      a   = ($urandom & 32'hFFFF_C000) | (32'(idx) << 2) | ($urandom & 32'h3);
      wb_issue($urandom_range(0, 1), a, $urandom, 4'($urandom_range(0, 15)), 0);
      wb_wait();
    end
    idle(3);

    // reset mid-burst with a pending Wishbone read
    tick();
    dma_sel = 1; A0 = 0; WE0 = 0;
    wb_pins(0, 32'h10, '0, 4'hF);
    for (int i = 1; i < 4; i++) begin
      tick();
      dma_sel = 1; A0 = i; WE0 = 0;
    end
    tick();
    rst = 1;
    dq.delete();
    wq.delete();
    seen_v = 0;
    seen_a = 0;
    dma_sel = 1; A0 = 4; WE0 = 0;
    for (int i = 5; i < 8; i++) begin
      tick();
      dma_sel = 1; A0 = i; WE0 = 0;
    end
    tick();
    rst = 0;
    check("rst2_Do0", Do0, 0);
    check("rst2_valid", Do0_valid, 0);
    check("rst2_ack", wbs_ack_o, 0);
    check("rst2_dat_o", wbs_dat_o, 0);
    idle(D + 10);
    check("rst2_no_valid", seen_v, 0);
    check("rst2_no_ack", seen_a, 0);
    for (int i = 0; i < 8; i++) dma_read(i);
    wb_issue(0, 32'h10, '0, 4'hF, 0);
    wb_wait();
    idle(D + 2);

    begin
      int k;
      k = 0;
      while ((dq.size() != 0 || wq.size() != 0) && k < 50) begin
        tick();
        k++;
      end
      check("drain_dq", dq.size(), 0);
      check("drain_wq", wq.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
